// File: rtl/alu_pkg.sv
// Shared ALU-control definitions: op codes, main-control encodings, funct3 values
// and the buffered entry layout used between ID and EX.
package alu_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned RD_W = 5;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLL = 4'b1111;

  localparam logic [1:0] MAIN_MEM = 2'b00;
  localparam logic [1:0] MAIN_BR  = 2'b01;
  localparam logic [1:0] MAIN_R   = 2'b10;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  typedef struct packed {
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [RD_W-1:0] rd;
    logic            illegal;
  } alu_entry_t;

  localparam alu_entry_t ENTRY_RESET = '{op: ALU_ADD, a: '0, b: '0, rd: '0, illegal: 1'b0};

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control decode: (main_op, funct3, funct7b5) -> (alu_op, illegal).
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] main_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_op,
  output logic       illegal
);

  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (main_op)
      MAIN_MEM: alu_op = ALU_ADD;
      MAIN_BR:  alu_op = ALU_SUB;
      MAIN_R: begin
        case (funct3)
          F3_ADDSUB: alu_op = funct7b5 ? ALU_SUB : ALU_ADD;
          F3_AND:    alu_op = ALU_AND;
          F3_OR:     alu_op = ALU_OR;
          F3_SLL:    alu_op = ALU_SLL;
          default:   illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_issue.sv
// ID->EX issue stage: decodes ALU control and buffers up to two entries (head + skid)
// behind valid/ready handshakes, with a registered in_ready and a flush.
module alu_ctrl_issue
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_main_op,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7b5,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [RD_W-1:0] in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_op,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [RD_W-1:0] out_rd,
  output logic            out_illegal
);

  logic [3:0] dec_op;
  logic       dec_illegal;

  alu_ctrl_decode u_decode (
    .main_op  (in_main_op),
    .funct3   (in_funct3),
    .funct7b5 (in_funct7b5),
    .alu_op   (dec_op),
    .illegal  (dec_illegal)
  );

  alu_entry_t new_entry;
  alu_entry_t head_q, head_d, skid_q, skid_d;
  logic [1:0] count_q, count_d;
  logic       in_ready_q, in_ready_d;
  logic       push, pop;

  assign new_entry = '{op: dec_op, a: in_a, b: in_b, rd: in_rd, illegal: dec_illegal};

  assign out_valid = (count_q != 2'd0);
  assign in_ready  = in_ready_q;
  // Flush wins over any transfer offered in the same cycle.
  assign push      = in_valid && in_ready_q && !flush;
  assign pop       = out_valid && out_ready;

  always_comb begin
    head_d  = head_q;
    skid_d  = skid_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_d = new_entry;
          else                 skid_d = new_entry;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd2) head_d = skid_q;
          count_d = count_q - 2'd1;
        end
        // Push+pop only happens at count 1 (in_ready excludes 2): new entry becomes head.
        2'b11: head_d = new_entry;
        default: ;
      endcase
    end
    in_ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q     <= ENTRY_RESET;
      skid_q     <= ENTRY_RESET;
      count_q    <= 2'd0;
      in_ready_q <= 1'b1;
    end else begin
      head_q     <= head_d;
      skid_q     <= skid_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign out_alu_op  = head_q.op;
  assign out_a       = head_q.a;
  assign out_b       = head_q.b;
  assign out_rd      = head_q.rd;
  assign out_illegal = head_q.illegal;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Bench for alu_ctrl_issue: scoreboard of expected entries plus per-scenario checks.
module tb_alu_ctrl_issue;
  import alu_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_main_op;
  logic [2:0]      in_funct3;
  logic            in_funct7b5;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic [RD_W-1:0] in_rd;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      out_alu_op;
  logic [XLEN-1:0] out_a;
  logic [XLEN-1:0] out_b;
  logic [RD_W-1:0] out_rd;
  logic            out_illegal;

  int vectors = 0;
  int miscompares = 0;
  alu_entry_t sb[$];

  alu_ctrl_issue dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_main_op  (in_main_op),
    .in_funct3   (in_funct3),
    .in_funct7b5 (in_funct7b5),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_rd       (in_rd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_alu_op  (out_alu_op),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_rd      (out_rd),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  // Reference decode: {illegal, op}
  function automatic logic [4:0] ref_dec(input logic [1:0] m, input logic [2:0] f3,
                                         input logic b5);
    case (m)
      2'b00: return 5'b0_0010;
      2'b01: return 5'b0_0110;
      2'b10: begin
        case (f3)
          3'b000:  return b5 ? 5'b0_0110 : 5'b0_0010;
          3'b111:  return 5'b0_0000;
          3'b110:  return 5'b0_0001;
          3'b001:  return 5'b0_1111;
          default: return 5'b1_0010;
        endcase
      end
      default: return 5'b1_0010;
    endcase
  endfunction

  task automatic drive(input logic [1:0] m, input logic [2:0] f3, input logic b5,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [RD_W-1:0] rd);
    in_valid    = 1'b1;
    in_main_op  = m;
    in_funct3   = f3;
    in_funct7b5 = b5;
    in_a        = a;
    in_b        = b;
    in_rd       = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on accepted input, pop/compare on accepted output.
  always @(negedge clk) begin
    alu_entry_t exp_e, got_e;
    logic [4:0] r;
    if (reset || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        vectors++;
        got_e = '{op: out_alu_op, a: out_a, b: out_b, rd: out_rd, illegal: out_illegal};
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL sb_unexpected: got op=%h a=%0h b=%0h rd=%0d ill=%b, required no output",
                   got_e.op, got_e.a, got_e.b, got_e.rd, got_e.illegal);
        end else begin
          exp_e = sb.pop_front();
          if (got_e !== exp_e) begin
            miscompares++;
            $display("FAIL sb_entry: got op=%h a=%0h b=%0h rd=%0d ill=%b, required op=%h a=%0h b=%0h rd=%0d ill=%b",
                     got_e.op, got_e.a, got_e.b, got_e.rd, got_e.illegal,
                     exp_e.op, exp_e.a, exp_e.b, exp_e.rd, exp_e.illegal);
          end
        end
      end
      if (in_valid && in_ready) begin
        r = ref_dec(in_main_op, in_funct3, in_funct7b5);
        sb.push_back('{op: r[3:0], a: in_a, b: in_b, rd: in_rd, illegal: r[4]});
      end
    end
  end

  task automatic test_reset();
    #2;
    vectors++;
    if ({out_valid, in_ready, out_alu_op, out_illegal} !== {1'b0, 1'b1, 4'b0010, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_ctrl: got valid=%b ready=%b op=%b ill=%b, required 0 1 0010 0",
               out_valid, in_ready, out_alu_op, out_illegal);
    end
    vectors++;
    if ({out_a, out_b, out_rd} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got a=%0h b=%0h rd=%0d, required 0 0 0", out_a, out_b, out_rd);
    end
    @(negedge clk);
    #2 reset = 1'b0;
    step();
  endtask

  task automatic test_rtype_sub();
    out_ready = 1'b1;
    drive(2'b10, 3'b000, 1'b1, 64'd10, 64'd3, 5'd7);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({out_valid, out_alu_op, out_illegal} !== {1'b1, 4'b0110, 1'b0} ||
        out_a !== 64'd10 || out_b !== 64'd3) begin
      miscompares++;
      $display("FAIL rtype_sub: got valid=%b op=%b a=%0d b=%0d ill=%b, required 1 0110 10 3 0",
               out_valid, out_alu_op, out_a, out_b, out_illegal);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [1:0] m[4]  = '{2'b00, 2'b01, 2'b10, 2'b10};
    logic [2:0] f3[4] = '{3'b000, 3'b000, 3'b111, 3'b001};
    logic [3:0] op[4] = '{4'b0010, 4'b0110, 4'b0000, 4'b1111};
    out_ready = 1'b1;
    drive(m[0], f3[0], 1'b0, 64'd100, 64'd200, 5'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      if (i < 3) drive(m[i+1], f3[i+1], 1'b0, 64'd101 + 64'(i), 64'd201 + 64'(i), 5'(i + 2));
      else       in_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_alu_op !== op[i]) begin
        miscompares++;
        $display("FAIL b2b_%0d: got valid=%b op=%b, required 1 %b", i, out_valid, out_alu_op, op[i]);
      end
    end
    step();
  endtask

  task automatic test_backpressure();
    logic rdy_exp[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int n;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) drive(2'b10, 3'b110, 1'b0, 64'd500 + 64'(k), 64'd600 + 64'(k), 5'(k + 10));
      @(negedge clk);
      vectors++;
      if (in_ready !== rdy_exp[k]) begin
        miscompares++;
        $display("FAIL bp_ready_%0d: got %b, required %b", k, in_ready, rdy_exp[k]);
      end
      if (k > 0) begin
        vectors++;
        if (out_valid !== 1'b1 || out_a !== 64'd500) begin
          miscompares++;
          $display("FAIL bp_stable_%0d: got valid=%b a=%0d, required 1 500", k, out_valid, out_a);
        end
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= 10) begin
      miscompares++;
      $display("FAIL bp_drain: got %0d entries left, required 0", sb.size());
    end
    step();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_after: got valid=%b ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_illegal();
    logic [1:0] m[3]  = '{2'b10, 2'b11, 2'b10};
    logic [2:0] f3[3] = '{3'b010, 3'b000, 3'b110};
    logic [4:0] r;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(m[i], f3[i], 1'b0, 64'd7 + 64'(i), 64'd9, 5'd3);
      r = ref_dec(m[i], f3[i], 1'b0);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_alu_op !== r[3:0] || out_illegal !== r[4]) begin
        miscompares++;
        $display("FAIL illegal_%0d: got valid=%b op=%b ill=%b, required 1 %b %b",
                 i, out_valid, out_alu_op, out_illegal, r[3:0], r[4]);
      end
      step();
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(2'b00, 3'b000, 1'b0, 64'd1, 64'd2, 5'd4);
    step();
    drive(2'b01, 3'b000, 1'b0, 64'd3, 64'd4, 5'd5);
    step();
    flush = 1'b1;
    drive(2'b10, 3'b111, 1'b0, 64'd5, 64'd6, 5'd6);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_pre: got valid=%b ready=%b, required 1 0", out_valid, in_ready);
    end
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL flush_post_%0d: got valid=%b ready=%b, required 0 1", i, out_valid, in_ready);
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(2'b10, 3'b001, 1'b0, 64'hdead, 64'hbeef, 5'd9);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || out_alu_op !== 4'b1111) begin
      miscompares++;
      $display("FAIL areset_pre: got valid=%b op=%b, required 1 1111", out_valid, out_alu_op);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({out_valid, in_ready, out_alu_op, out_illegal} !== {1'b0, 1'b1, 4'b0010, 1'b0} ||
        out_a !== '0 || out_b !== '0 || out_rd !== '0) begin
      miscompares++;
      $display("FAIL areset: got valid=%b ready=%b op=%b a=%0h b=%0h rd=%0d, required 0 1 0010 0 0 0",
               out_valid, in_ready, out_alu_op, out_a, out_b, out_rd);
    end
    @(negedge clk);
    #2 reset = 1'b0;
    out_ready = 1'b1;
    step();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL areset_post: got valid=%b, required 0", out_valid);
    end
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_main_op = '0;
    in_funct3 = '0;
    in_funct7b5 = 1'b0;
    in_a = '0;
    in_b = '0;
    in_rd = '0;
    out_ready = 1'b0;
    test_reset();
    test_rtype_sub();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_flush();
    test_async_reset();
    step();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: got %0d entries, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish by 100000, required finish");
    $fatal(1, "timeout");
  end

endmodule
